// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix ALU and its memory bank: geometry, element and
// dimension types, ALU opcodes and the slot/row/col -> word address mapping.
package matrix_pkg;

    localparam int DATA_W     = 16;
    localparam int MAX_DIM    = 5;
    localparam int SLOTS      = 4;
    localparam int SLOT_C     = 2;
    localparam int SLOT_WORDS = MAX_DIM * MAX_DIM;
    localparam int WORDS      = SLOTS * SLOT_WORDS;
    localparam int ADDR_W     = $clog2(WORDS);

    typedef logic [DATA_W-1:0] elem_t;
    typedef logic [2:0]        dim_t;
    typedef logic [1:0]        slot_t;
    typedef logic [ADDR_W-1:0] word_t;

    typedef enum logic [2:0] {
        OP_ADD       = 3'd0,
        OP_SUB       = 3'd1,
        OP_MUL       = 3'd2,
        OP_SCALE     = 3'd3,
        OP_TRANSPOSE = 3'd4
    } alu_op_e;

    // Row-major within a slot; out-of-range row/col still map to a (meaningless) word.
    function automatic word_t word_addr(slot_t slot, dim_t row, dim_t col);
        return word_t'(slot) * word_t'(SLOT_WORDS) + word_t'(row) * word_t'(MAX_DIM) + word_t'(col);
    endfunction

    function automatic logic dims_ok(dim_t m, dim_t n);
        return (m != '0) && (n != '0) && (int'(m) <= MAX_DIM) && (int'(n) <= MAX_DIM);
    endfunction

endpackage

// File: rtl/matrix_addr_calc.sv
// Combinational slot/row/col to word-address translation with an in-range flag
// for row/col against the maximum matrix dimension.
module matrix_addr_calc
    import matrix_pkg::*;
(
    input  logic [1:0] slot,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic [6:0] word,
    output logic       in_range
);

    assign word     = word_addr(slot, row, col);
    assign in_range = (int'(row) < MAX_DIM) && (int'(col) < MAX_DIM);

endmodule

// File: rtl/matrix_mem_bank.sv
// Four-slot matrix store: combinational reads for the ALU, ALU and host write ports
// sharing one element write port, and a zeroing sequencer used after reset and on clear.
module matrix_mem_bank
    import matrix_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mem_rd_slot,
    input  logic [2:0]  mem_rd_row,
    input  logic [2:0]  mem_rd_col,
    output logic [15:0] mem_rd_data,
    output logic [2:0]  mem_current_m,
    output logic [2:0]  mem_current_n,
    output logic        mem_rd_valid,
    input  logic [1:0]  mem_wr_slot,
    input  logic [2:0]  mem_wr_row,
    input  logic [2:0]  mem_wr_col,
    input  logic [15:0] mem_wr_data,
    input  logic        mem_wr_we,
    input  logic [2:0]  mem_res_m,
    input  logic [2:0]  mem_res_n,
    input  logic        mem_dim_we,
    input  logic        host_req,
    input  logic        host_dim,
    input  logic [1:0]  host_slot,
    input  logic [2:0]  host_row,
    input  logic [2:0]  host_col,
    input  logic [15:0] host_data,
    input  logic [2:0]  host_m,
    input  logic [2:0]  host_n,
    output logic        host_ack,
    input  logic        clear_req,
    input  logic [1:0]  clear_slot,
    input  logic        clear_all,
    output logic        busy,
    output logic        clear_done,
    output logic        wr_err
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_CLEAR} state_e;

    state_e state_q, state_d;
    word_t  cnt_q, cnt_d;
    word_t  base_q, base_d;
    word_t  last_q, last_d;
    dim_t   dim_m_q [SLOTS];
    dim_t   dim_m_d [SLOTS];
    dim_t   dim_n_q [SLOTS];
    dim_t   dim_n_d [SLOTS];
    logic [SLOTS-1:0] valid_q, valid_d;
    logic   host_ack_q, host_ack_d;
    logic   clear_done_q, clear_done_d;
    logic   wr_err_q, wr_err_d;

    elem_t  mem [WORDS];
    logic   wr_en;
    word_t  wr_addr;
    elem_t  wr_data;

    word_t  rd_word, alu_word, host_word;
    logic   rd_in_range, alu_in_range, host_in_range;
    logic   alu_strobe, host_serve;

    matrix_addr_calc u_rd_addr (
        .slot(mem_rd_slot), .row(mem_rd_row), .col(mem_rd_col),
        .word(rd_word), .in_range(rd_in_range)
    );

    matrix_addr_calc u_alu_addr (
        .slot(mem_wr_slot), .row(mem_wr_row), .col(mem_wr_col),
        .word(alu_word), .in_range(alu_in_range)
    );

    matrix_addr_calc u_host_addr (
        .slot(host_slot), .row(host_row), .col(host_col),
        .word(host_word), .in_range(host_in_range)
    );

    // The ALU owns the write port whenever it strobes; the host waits, and is never
    // re-served in the ack cycle because its request is still high then.
    assign alu_strobe = mem_wr_we | mem_dim_we;
    assign host_serve = (state_q == S_IDLE) && host_req && !host_ack_q && !alu_strobe;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        last_d       = last_q;
        dim_m_d      = dim_m_q;
        dim_n_d      = dim_n_q;
        valid_d      = valid_q;
        host_ack_d   = 1'b0;
        clear_done_d = 1'b0;
        wr_err_d     = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;

        case (state_q)
            S_INIT, S_CLEAR: begin
                wr_en    = 1'b1;
                wr_addr  = base_q + cnt_q;
                wr_err_d = alu_strobe;
                if (cnt_q == last_q) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    clear_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_IDLE: begin
                if (mem_wr_we) begin
                    if (alu_in_range) begin
                        wr_en   = 1'b1;
                        wr_addr = alu_word;
                        wr_data = mem_wr_data;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end

                if (mem_dim_we) begin
                    if (dims_ok(mem_res_m, mem_res_n)) begin
                        dim_m_d[mem_wr_slot] = mem_res_m;
                        dim_n_d[mem_wr_slot] = mem_res_n;
                        valid_d[mem_wr_slot] = 1'b1;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end

                if (host_serve) begin
                    host_ack_d = 1'b1;
                    if (host_dim) begin
                        if (dims_ok(host_m, host_n)) begin
                            dim_m_d[host_slot] = host_m;
                            dim_n_d[host_slot] = host_n;
                            valid_d[host_slot] = 1'b1;
                        end else begin
                            wr_err_d = 1'b1;
                        end
                    end else if (host_in_range) begin
                        wr_en   = 1'b1;
                        wr_addr = host_word;
                        wr_data = host_data;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end

                // A same-cycle write still lands; the zeroing sweep starts on the next edge.
                if (clear_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    if (clear_all) begin
                        base_d = '0;
                        last_d = word_t'(WORDS - 1);
                        for (int i = 0; i < SLOTS; i++) begin
                            dim_m_d[i] = '0;
                            dim_n_d[i] = '0;
                        end
                        valid_d = '0;
                    end else begin
                        base_d              = word_addr(clear_slot, 3'd0, 3'd0);
                        last_d              = word_t'(SLOT_WORDS - 1);
                        dim_m_d[clear_slot] = '0;
                        dim_n_d[clear_slot] = '0;
                        valid_d[clear_slot] = 1'b0;
                    end
                end
            end

            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            base_q       <= '0;
            last_q       <= word_t'(WORDS - 1);
            for (int i = 0; i < SLOTS; i++) begin
                dim_m_q[i] <= '0;
                dim_n_q[i] <= '0;
            end
            valid_q      <= '0;
            host_ack_q   <= 1'b0;
            clear_done_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            last_q       <= last_d;
            dim_m_q      <= dim_m_d;
            dim_n_q      <= dim_n_d;
            valid_q      <= valid_d;
            host_ack_q   <= host_ack_d;
            clear_done_q <= clear_done_d;
            wr_err_q     <= wr_err_d;
        end
    end

    // NOTE: the array has no reset branch so it maps onto plain RAM; the INIT sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign mem_rd_data   = rd_in_range ? mem[rd_word] : '0;
    assign mem_current_m = dim_m_q[mem_rd_slot];
    assign mem_current_n = dim_n_q[mem_rd_slot];
    assign mem_rd_valid  = valid_q[mem_rd_slot];

    assign busy       = (state_q != S_IDLE);
    assign host_ack   = host_ack_q;
    assign clear_done = clear_done_q;
    assign wr_err     = wr_err_q;

endmodule
